// File: rtl/seq_mul_shift_add.sv
// Sequential shift-add multiplier with start/ready/done handshake.
// One multiplier bit is retired per cycle through a single WIDTH-bit adder;
// signed operation multiplies magnitudes and negates the 2*WIDTH-bit result.
module seq_mul_shift_add #(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [WIDTH-1:0]   m_reg;
  logic [WIDTH-1:0]   q_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               neg_reg;
  logic [2*WIDTH-1:0] product_reg;

  logic               accept;
  logic [CNT_W-1:0]   count_inc;
  logic               last_step;
  logic [WIDTH-1:0]   m_gated;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_final;
  logic [WIDTH-1:0]   m_mag;
  logic [WIDTH-1:0]   q_mag;
  logic               neg_in;

  assign accept = start & ready;

  // Operand magnitudes; -2^(W-1) maps to 2^(W-1), which still fits W bits unsigned.
  assign m_mag  = (signed_mode && multiplicand[WIDTH-1]) ? (~multiplicand + 1'b1) : multiplicand;
  assign q_mag  = (signed_mode && multiplier[WIDTH-1])   ? (~multiplier + 1'b1)   : multiplier;
  assign neg_in = signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);

  // Partial product: multiplicand gated by the current low multiplier bit.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
      assign m_gated[gi] = m_reg[gi] & q_reg[0];
    end
  endgenerate

  // The adder carry becomes the accumulator MSB after the right shift.
  assign sum        = {1'b0, a_reg} + {1'b0, m_gated};
  assign prod_raw   = {sum, q_reg[WIDTH-1:1]};
  assign prod_final = neg_reg ? (~prod_raw + 1'b1) : prod_raw;
  assign count_inc  = count_reg + CNT_W'(1);
  // The step that brings the count to WIDTH is the last; its result is final.
  assign last_step  = (count_inc == CNT_W'(WIDTH));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic and handshake outputs decoded from state.
  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        ready      = 1'b1;
        done       = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, shift-add while running, capture result on last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_reg       <= '0;
      q_reg       <= '0;
      a_reg       <= '0;
      count_reg   <= '0;
      neg_reg     <= 1'b0;
      product_reg <= '0;
    end else if (accept) begin
      m_reg     <= m_mag;
      q_reg     <= q_mag;
      a_reg     <= '0;
      count_reg <= '0;
      neg_reg   <= neg_in;
    end else if (state_reg == RUN) begin
      a_reg     <= sum[WIDTH:1];
      q_reg     <= {sum[0], q_reg[WIDTH-1:1]};
      count_reg <= count_inc;
      if (last_step) product_reg <= prod_final;
    end
  end

  assign product = product_reg;

endmodule

// File: tb/tb_seq_mul_shift_add.sv
// Testbench for seq_mul_shift_add (WIDTH=16): directed vector table,
// multi-cycle handshake corner cases and randomized operations against
// an arithmetic reference model.
module tb_seq_mul_shift_add;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          signed_mode;
  logic [W-1:0]  multiplicand;
  logic [W-1:0]  multiplier;
  logic          ready;
  logic          busy;
  logic          done;
  logic [2*W-1:0] product;

  int errors = 0;
  int checks = 0;

  seq_mul_shift_add #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .ready        (ready),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          sm;
    logic [W-1:0]  m;
    logic [W-1:0]  q;
    logic [2*W-1:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Reference: plain integer multiplication of the interpreted operands.
  function automatic logic [2*W-1:0] ref_mul(input logic sm, input logic [W-1:0] m, input logic [W-1:0] q);
    longint a;
    longint b;
    if (sm) begin
      a = longint'($signed(m));
      b = longint'($signed(q));
    end else begin
      a = longint'({48'd0, m});
      b = longint'({48'd0, q});
    end
    return (2*W)'(a * b);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation while ready; returns in the done cycle (or after a timeout).
  task automatic do_op(input logic sm, input logic [W-1:0] m, input logic [W-1:0] q,
                       output logic [2*W-1:0] prod, output int lat, output int busy_bad);
    signed_mode  = sm;
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    multiplicand = W'($urandom);
    multiplier   = W'($urandom);
    signed_mode  = 1'($urandom);
    lat      = 0;
    busy_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      if (!busy || ready) busy_bad++;
      tick();
    end
    prod = product;
  endtask

  vec_t           vecs[7];
  logic [2*W-1:0] prod;
  logic [2*W-1:0] exp_p;
  int             lat;
  int             busy_bad;
  int             done_cnt;
  int             first_done;
  int             second_done;
  logic [2*W-1:0] prod_at_second;
  logic           sm_r;
  logic [W-1:0]   m_r;
  logic [W-1:0]   q_r;

  initial begin
    vecs[0] = '{1'b0, 16'h0003, 16'h0005, 32'h0000000F};
    vecs[1] = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[2] = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001};
    vecs[3] = '{1'b1, 16'h8000, 16'h8000, 32'h40000000};
    vecs[4] = '{1'b1, 16'h8000, 16'h0001, 32'hFFFF8000};
    vecs[5] = '{1'b1, 16'h0007, 16'hFFFD, 32'hFFFFFFEB};
    vecs[6] = '{1'b0, 16'h0000, 16'h1234, 32'h00000000};

    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; multiplicand = '0; multiplier = '0;
    tick(); tick(); tick();
    check("reset ready", 64'(ready), 64'd1);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset product", 64'(product), 64'd0);
    rst = 1'b0;
    tick();

    // Directed table; consecutive entries start in the done cycle of the previous one.
    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].sm, vecs[i].m, vecs[i].q, prod, lat, busy_bad);
      check($sformatf("vec%0d product", i), 64'(prod), 64'(vecs[i].exp));
      check($sformatf("vec%0d latency", i), 64'(lat), 64'd17);
      check($sformatf("vec%0d busy T1..T16", i), 64'(busy_bad), 64'd0);
    end

    // Result held and done deasserted afterwards.
    tick();
    check("hold done low", 64'(done), 64'd0);
    check("hold ready", 64'(ready), 64'd1);
    tick();
    check("hold product", 64'(product), 64'(vecs[6].exp));

    // Product of 3*5 first so the not-cleared-on-accept check has a nonzero value.
    do_op(1'b0, 16'd3, 16'd5, prod, lat, busy_bad);
    tick();
    // Start during RUN must be ignored.
    signed_mode = 1'b0; multiplicand = 16'd11; multiplier = 16'd13; start = 1'b1;
    tick();
    start = 1'b0; multiplicand = 16'd9; multiplier = 16'd9;
    done_cnt = 0; first_done = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 3) check("product held during RUN", 64'(product), 64'h0F);
      if (c == 5) start = 1'b1;
      if (c == 6) start = 1'b0;
      if (done) begin
        done_cnt++;
        if (first_done == 0) first_done = c;
      end
      if (c == 17) prod = product;
      tick();
    end
    check("ignored start done count", 64'(done_cnt), 64'd1);
    check("ignored start done cycle", 64'(first_done), 64'd17);
    check("ignored start product", 64'(prod), 64'h8F);

    // Start held high through DONE: back-to-back 2*2.
    signed_mode = 1'b0; multiplicand = 16'd2; multiplier = 16'd2; start = 1'b1;
    tick();
    first_done = 0; second_done = 0; prod_at_second = '0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        if (first_done == 0) first_done = c;
        else if (second_done == 0) begin
          second_done    = c;
          prod_at_second = product;
          start          = 1'b0;
        end
      end
      tick();
    end
    check("b2b first done", 64'(first_done), 64'd17);
    check("b2b second done", 64'(second_done), 64'd34);
    check("b2b product", 64'(prod_at_second), 64'h4);

    // Reset in the middle of an operation (3*5 whilst product holds 4).
    multiplicand = 16'd3; multiplier = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    rst = 1'b1;
    tick();
    check("mid rst ready", 64'(ready), 64'd1);
    check("mid rst busy", 64'(busy), 64'd0);
    check("mid rst product", 64'(product), 64'd0);
    rst = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (done || busy) done_cnt++;
      tick();
    end
    check("mid rst no activity", 64'(done_cnt), 64'd0);
    do_op(1'b0, 16'd6, 16'd7, prod, lat, busy_bad);
    check("after rst 6*7", 64'(prod), 64'h2A);
    check("after rst latency", 64'(lat), 64'd17);
    tick();

    // Reset and start together: reset wins.
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst+start busy", 64'(busy), 64'd0);
    tick();
    check("rst+start still idle", 64'({busy, ready}), 64'b01);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      sm_r = 1'($urandom);
      m_r  = W'($urandom);
      q_r  = W'($urandom);
      if (i % 8 == 0) m_r = 16'h8000;
      exp_p = ref_mul(sm_r, m_r, q_r);
      do_op(sm_r, m_r, q_r, prod, lat, busy_bad);
      check($sformatf("rnd%0d s=%0d %h*%h", i, sm_r, m_r, q_r), 64'(prod), 64'(exp_p));
      if (lat != 17) check($sformatf("rnd%0d latency", i), 64'(lat), 64'd17);
      if (i % 3 == 0) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
